// File: rtl/regfile_write_queue.sv
// regfile_write_queue: 16-entry register file fed through an in-order write queue,
// with registered reads that forward the youngest matching queued write.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [3:0]               wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     drain_hold,
    input  logic                     rd_valid,
    input  logic [3:0]               rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_data_valid,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int PW = $clog2(DEPTH);
    logic [3:0]       q_addr [DEPTH];
    logic [WIDTH-1:0] q_data [DEPTH];
    logic [WIDTH-1:0] regs [16];
    logic [PW-1:0]    wp, rp;
    logic [PW:0]      cnt;
    logic             push, retire;
    logic [15:0]      we;
    logic [WIDTH-1:0] rd_next;
    assign wr_ready = cnt != (PW+1)'(DEPTH);
    assign push     = wr_valid && wr_ready;
    assign retire   = cnt != '0 && !drain_hold;
    assign we       = retire ? 16'(1) << q_addr[rp] : '0;
    assign pending  = cnt;
    // Scan oldest to youngest so the last match, the youngest write, wins.
    always_comb begin
        rd_next = regs[rd_addr];
        for (int i = 0; i < DEPTH; i++)
            if ((PW+1)'(i) < cnt && q_addr[rp + PW'(i)] == rd_addr)
                rd_next = q_data[rp + PW'(i)];
    end
    always_ff @(posedge clk)
        if (push) begin
            q_addr[wp] <= wr_addr;
            q_data[wp] <= wr_data;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp            <= '0;
            rp            <= '0;
            cnt           <= '0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            for (int r = 0; r < 16; r++) regs[r] <= '0;
        end else begin
            wp            <= wp + PW'(push);
            rp            <= rp + PW'(retire);
            cnt           <= cnt + (PW+1)'(push) - (PW+1)'(retire);
            rd_data_valid <= rd_valid;
            if (rd_valid) rd_data <= rd_next;
            for (int r = 0; r < 16; r++) if (we[r]) regs[r] <= q_data[rp];
        end
endmodule

// File: doc/regfile_write_queue.md
REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-queue entry count (power of 2, 2..8).
REQ-002 SHALL have parameter WIDTH, default 32, register data width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_valid  input  1  write request present.
REQ-007 wr_ready  output  1  queue can accept a write.
REQ-008 wr_addr  input  4  destination register, 0..15.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 drain_hold  input  1  when 1, the queue head is not retired this cycle.
REQ-011 rd_valid  input  1  read request; always accepted.
REQ-012 rd_addr  input  4  register to read.
REQ-013 rd_data  output  WIDTH  read result, registered.
REQ-014 rd_data_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015 pending  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-016 SHALL hold 16 registers of WIDTH bits; no register is hard-wired.
REQ-017 SHALL accept a write on any edge where wr_valid and wr_ready are both 1, appending {wr_addr, wr_data} at the queue tail.
REQ-018 wr_ready SHALL be 1 iff pending < DEPTH, decoded from registered occupancy only, with no combinational path from drain_hold or wr_valid.
REQ-019 On each edge where pending > 0 and drain_hold = 0, SHALL write the head entry into register[head.addr] through a one-hot 16-way write-enable decode, then retire it.
REQ-020 Simultaneous push and retire SHALL leave pending unchanged.
REQ-021 Push alone SHALL increment pending; retire alone SHALL decrement it.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH.
REQ-023 A push while full SHALL be impossible by REQ-018; wr_valid while full SHALL be ignored and nothing overwritten.
REQ-024 A retire while empty SHALL do nothing.
REQ-025 A read accepted on edge N SHALL drive rd_data and rd_data_valid = 1 after edge N, giving 1-cycle latency.
REQ-026 If rd_valid = 0 at edge N, rd_data_valid SHALL be 0 after edge N and rd_data SHALL hold its previous value.
REQ-027 Read value SHALL reflect all writes accepted before edge N, in program order, selected as follows:
- the youngest queue entry (pre-edge contents, including the head being retired at N) with addr = rd_addr;
- otherwise the array value before edge N.
REQ-028 A write accepted at the same edge N as a read SHALL NOT be visible to that read.
REQ-029 The read select SHALL be a 16:1 mux on the array, followed by a DEPTH-way youngest-match forward mux.
REQ-030 Multiple queued writes to the same address SHALL retire in order, so the last accepted write wins in the array.

Reset
REQ-031 While rst_n = 0, all 16 registers SHALL be 0.
REQ-032 While rst_n = 0, the queue SHALL be empty with pointers at 0, pending = 0 and wr_ready = 1.
REQ-033 While rst_n = 0, rd_data SHALL be 0 and rd_data_valid SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard all queued writes and in-flight reads with no partial array update.
REQ-035 The first edge after deassertion SHALL behave as normal operation.

Verification
REQ-036 Basic write then read:
- Stimulus: after reset, write r3 = 0xDEADBEEF with drain_hold = 0; two cycles later read r3.
- Response: rd_data = 0xDEADBEEF with rd_data_valid = 1 one cycle after the read; pending returns to 0.
REQ-037 Fill and drain:
- Stimulus: drain_hold = 1; write r1..r4 = 0x11, 0x22, 0x33, 0x44.
- Response: pending = 4 and wr_ready = 0; a 5th wr_valid is dropped.
- Stimulus: release drain_hold.
- Response: pending steps 3, 2, 1, 0 on consecutive edges; the array holds the four values.
REQ-038 Forwarding, youngest wins:
- Stimulus: drain_hold = 1; write r5 = 0xA, then r5 = 0xB; then read r5.
- Response: rd_data = 0xB.
- Stimulus: read r6.
- Response: rd_data = 0 (array value).
REQ-039 Same-edge write and read:
- Stimulus: with r7 = 0x1 already in the array, write r7 = 0x2 and read r7 on the same edge.
- Response: rd_data = 0x1; a read on the next edge returns 0x2.
REQ-040 Simultaneous push and retire at steady state:
- Stimulus: one write per cycle with drain_hold = 0, for 20 cycles to rotating addresses.
- Response: pending stays 1; pointers wrap; all 16 registers match a reference model.
REQ-041 Reset mid-operation:
- Stimulus: queue holding 3 entries plus a pending read; assert rst_n = 0 asynchronously.
- Response: pending = 0, rd_data_valid = 0 and all registers 0 immediately; post-reset reads return 0.
